// File: rtl/idli_pkg.sv
// Shared IDLI definitions.
// SQI memory modes, commands and controller states.
package idli_pkg;

  localparam logic SQI_IO_MODE_OUT = 1'b0;
  localparam logic SQI_IO_MODE_IN  = 1'b1;

  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    DONE
  } sqi_ctrl_state_t;

  function automatic int sqi_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/idli_sqi_ctrl_m.sv
// SQI SRAM controller: one word-sized read or write per request,
// nibble-serial over SCK with handshake-driven SCK stalls.
module idli_sqi_ctrl_m
  import idli_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_NIB  = 4,
  parameter int DUMMY_NIB = 2
) (
  input  logic              i_sqi_gck,
  input  logic              i_sqi_rst_n,
  input  logic              i_sqi_req_vld,
  input  logic              i_sqi_req_wr,
  input  logic [ADDR_W-1:0] i_sqi_req_addr,
  output logic              o_sqi_req_rdy,
  input  logic [3:0]        i_sqi_wdata,
  input  logic              i_sqi_wdata_vld,
  output logic              o_sqi_wdata_acp,
  output logic [3:0]        o_sqi_rdata,
  output logic              o_sqi_rdata_vld,
  input  logic              i_sqi_rdata_acp,
  output logic              o_sqi_mem_sck,
  output logic              o_sqi_mem_cs,
  output logic              o_sqi_mem_io_mode,
  input  logic [3:0]        i_sqi_mem_sio,
  output logic [3:0]        o_sqi_mem_sio
);

  localparam int ADDR_NIB = ADDR_W / 4;
  localparam int CNT_MAX  =
    sqi_max(sqi_max(ADDR_NIB, DATA_NIB), sqi_max(DUMMY_NIB, 2));
  localparam int CNT_W    = $clog2(CNT_MAX);
  localparam int SR_W     = ADDR_W + 4;

  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_NIB - 1);
  localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_NIB - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_NIB - 1);

  sqi_ctrl_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic             wr_q, wr_d;
  logic             sck_q, sck_d;
  logic             cs_q, cs_d;
  logic             io_q, io_d;
  logic [3:0]       sio_q, sio_d;
  logic [3:0]       rdata_q, rdata_d;
  logic             rvld_q, rvld_d;

  logic       nib_last;
  logic       go_hi;
  logic [7:0] cmd;

  assign o_sqi_req_rdy = (state_q == IDLE) && !rvld_q;
  assign o_sqi_wdata_acp =
    (state_q == DATA) && wr_q && !sck_q && i_sqi_wdata_vld;

  assign o_sqi_mem_sck     = sck_q;
  assign o_sqi_mem_cs      = cs_q;
  assign o_sqi_mem_io_mode = io_q;
  assign o_sqi_mem_sio     = sio_q;
  assign o_sqi_rdata       = rdata_q;
  assign o_sqi_rdata_vld   = rvld_q;

  always_comb begin
    nib_last = 1'b0;
    unique case (state_q)
      CMD:     nib_last = (cnt_q == CMD_LAST);
      ADDR:    nib_last = (cnt_q == ADDR_LAST);
      DUMMY:   nib_last = (cnt_q == DUMMY_LAST);
      DATA:    nib_last = (cnt_q == DATA_LAST);
      default: nib_last = 1'b0;
    endcase
  end

  // Data LO phases wait on the core: write needs a nibble,
  // read needs room for the next captured nibble.
  always_comb begin
    go_hi = 1'b1;
    if (state_q == DATA) begin
      if (wr_q) go_hi = i_sqi_wdata_vld;
      else      go_hi = !(rvld_q && !i_sqi_rdata_acp);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    wr_d    = wr_q;
    sck_d   = sck_q;
    cs_d    = cs_q;
    io_d    = io_q;
    sio_d   = sio_q;
    rdata_d = rdata_q;
    rvld_d  = rvld_q;
    cmd     = i_sqi_req_wr ? SQI_CMD_WRITE : SQI_CMD_READ;

    if (rvld_q && i_sqi_rdata_acp) rvld_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_sqi_req_vld && o_sqi_req_rdy) begin
          wr_d    = i_sqi_req_wr;
          cs_d    = 1'b0;
          cnt_d   = '0;
          sio_d   = cmd[7:4];
          sr_d    = {cmd[3:0], i_sqi_req_addr};
          state_d = CMD;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        if (!sck_q) begin
          sck_d = go_hi;
          if (o_sqi_wdata_acp) sio_d = i_sqi_wdata;
        end else begin
          sck_d = 1'b0;
          cnt_d = nib_last ? '0 : cnt_q + CNT_W'(1);
          if (state_q == DATA && !wr_q) begin
            rdata_d = i_sqi_mem_sio;
            rvld_d  = 1'b1;
          end
          if (state_q == CMD || (state_q == ADDR && !nib_last)) begin
            sio_d = sr_q[SR_W-1 -: 4];
            sr_d  = sr_q << 4;
          end
          if (nib_last) begin
            unique case (state_q)
              CMD: state_d = ADDR;
              ADDR: begin
                if (wr_q) begin
                  state_d = DATA;
                end else begin
                  state_d = DUMMY;
                  io_d    = SQI_IO_MODE_IN;
                  sio_d   = '0;
                end
              end
              DUMMY: state_d = DATA;
              DATA: begin
                state_d = DONE;
                cs_d    = 1'b1;
                io_d    = SQI_IO_MODE_OUT;
                sio_d   = '0;
              end
              default: state_d = state_q;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      wr_q    <= 1'b0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      io_q    <= SQI_IO_MODE_OUT;
      sio_q   <= '0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      wr_q    <= wr_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      io_q    <= io_d;
      sio_q   <= sio_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
    end
  end

endmodule

// File: doc/idli_sqi_ctrl_m.md
Name: idli_sqi_ctrl_m

Overview:
Parametrised SQI SRAM controller. It replaces the tied-off memory pins of the core top level with a real read/write engine.
- Accepts one word-sized request at a time.
- Serialises command, address and dummy phases as nibbles on the SQI bus.
- Streams data nibbles to and from the core over valid/accept handshakes, stalling SCK under backpressure.
- Sits between the core datapath and the o_core_mem_* / i_core_mem_sio pins.

Parameters:
ADDR_W, 16, address width in bits; multiple of 4; sent as ADDR_W/4 nibbles, MSB nibble first.
DATA_NIB, 4, data nibbles per transfer; must be 1 or more.
DUMMY_NIB, 2, turnaround nibbles before read data; must be 1 or more.

Ports:
i_sqi_gck  in  1  clock
i_sqi_rst_n  in  1  reset, asynchronous, active-low
i_sqi_req_vld  in  1  request valid
i_sqi_req_wr  in  1  1 = write, 0 = read
i_sqi_req_addr  in  ADDR_W  request address
o_sqi_req_rdy  out  1  request accepted when vld && rdy
i_sqi_wdata  in  4  write nibble
i_sqi_wdata_vld  in  1  write nibble valid
o_sqi_wdata_acp  out  1  write nibble consumed this cycle
o_sqi_rdata  out  4  read nibble
o_sqi_rdata_vld  out  1  read nibble valid
i_sqi_rdata_acp  in  1  read nibble consumed
o_sqi_mem_sck  out  1  SQI clock
o_sqi_mem_cs  out  1  chip select, active-low
o_sqi_mem_io_mode  out  1  SQI_IO_MODE_OUT or SQI_IO_MODE_IN
i_sqi_mem_sio  in  4  SQI data from memory
o_sqi_mem_sio  out  4  SQI data to memory

Behaviour:
- Clock and reset: one clock, i_sqi_gck; reset i_sqi_rst_n is asynchronous, active-low.
- Reset values: cs=1, sck=0, io_mode=OUT, mem_sio=0, rdata=0, rdata_vld=0, wdata_acp=0, state=IDLE. These take effect immediately on assertion, including mid-transfer; a partial transfer is abandoned.
- Registered outputs: all outputs are registered except o_sqi_req_rdy and o_sqi_wdata_acp.
- o_sqi_req_rdy = (state==IDLE) && !o_sqi_rdata_vld.
- Nibble timing: each nibble takes two cycles.
  - LO phase: sck=0, mem_sio updated.
  - HI phase: sck=1; the memory samples on the rising edge.
  - Read nibbles are captured from i_sqi_mem_sio on the clock edge that ends HI.
- State machine: IDLE -> CMD (2 nibbles) -> ADDR (ADDR_W/4) -> [read: DUMMY (DUMMY_NIB)] -> DATA (DATA_NIB) -> DONE (1 cycle, cs=1) -> IDLE.
- Request acceptance: on the accepting edge, addr and wr are latched, cs falls, and the first LO phase begins in the next cycle (cycle 1). Command = SQI_CMD_WRITE (0x02) or SQI_CMD_READ (0x03), high nibble first.
- Read turnaround: io_mode switches to IN on the first LO phase of DUMMY and returns to OUT in DONE. mem_sio drives 0 whenever io_mode=IN.
- Write data handshake:
  - A DATA LO phase waits, with sck held 0, until i_sqi_wdata_vld.
  - o_sqi_wdata_acp = (state==DATA, write, LO phase, wdata_vld), combinational.
  - The nibble is registered onto mem_sio at that edge; HI follows in the next cycle.
- Read data handshake:
  - The captured nibble sets rdata_vld, which holds with rdata stable until i_sqi_rdata_acp.
  - The next HI phase is not entered while rdata_vld && !rdata_acp; sck stays 0, which is legal for static SRAM.
  - Capture and acp in the same cycle: the new nibble replaces the old one and vld stays 1.
- Read tail: the last read nibble may remain pending after DONE/IDLE; rdy stays low until it is accepted.
- Counters: one nibble counter, width $clog2 of max(ADDR_W/4, DATA_NIB, DUMMY_NIB, 2). It reloads at each phase change and never wraps within a phase.
- Unstalled latency, defaults:
  - Write: cs high at cycle 21, rdy at cycle 22.
  - Read: first rdata_vld at cycle 19, last at cycle 25, cs high at 25.
- req_vld while busy is ignored (rdy=0); addr/wr changes after acceptance have no effect.

Decomposition:
- idli_pkg additions: SQI_CMD_READ, SQI_CMD_WRITE (8-bit localparams); sqi_ctrl_state_t enum {IDLE, CMD, ADDR, DUMMY, DATA, DONE}. Reuse the existing SQI_IO_MODE_IN/OUT.
- A single module is natural; the command/address shift register is inline. No sub-module.

Test Plan:
- Write, addr=0x1234, wdata nibbles A,B,C,D always valid -> mem_sio over HI phases: 0,2,1,2,3,4,A,B,C,D; 10 sck rising edges; cs low cycles 1-20, high at 21; rdy at 22.
- Read, addr=0xBEEF, memory model returns 5,6,7,8 with rdata_acp tied high -> sio out 0,3,B,E,E,F; io_mode=IN from cycle 13; rdata 5,6,7,8 valid at cycles 19,21,23,25.
- Read with rdata_acp low for 5 cycles after the first nibble -> sck held 0, rdata=5 stable, no second rising edge until acp; all 4 nibbles correct in order.
- Write with wdata_vld deasserted for 3 cycles before the 3rd nibble -> sck held 0, wdata_acp exactly 4 pulses, nibble order preserved.
- Reset asserted during ADDR of a read -> cs=1, sck=0, io_mode=OUT in the same cycle; after release, rdy=1 and a fresh write completes correctly.
- ADDR_W=24, DATA_NIB=2, DUMMY_NIB=2 read of addr=0x012345 -> 6 address nibbles 0,1,2,3,4,5; 2 data nibbles; cs high at cycle 25.
